uart_tx_arbiter: RTL and testbench

//   Shares the single transmitter of uart_top between NREQ byte sources. Round-robin

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for UART transmit-side controllers: sequencer states and a
// constant-foldable ceil(log2) helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Ceiling log2 with a floor of 1 so single-entry indices still get a bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin grant selection: first requester found searching last+1, last+2, ...
// (mod NREQ). Purely combinational.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [clog2(NREQ)-1:0]   last,
  output logic [NREQ-1:0]          gnt_onehot,
  output logic [clog2(NREQ)-1:0]   gnt_idx,
  output logic                     any
);

  localparam int unsigned IW = clog2(NREQ);

  function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    return IW'(s % NREQ);
  endfunction

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!any && req[slot(last, k)]) begin
        any                       = 1'b1;
        gnt_idx                   = slot(last, k);
        gnt_onehot[slot(last, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte sources: round-robin grant,
// start pulse, wait for done, with a watchdog that abandons a stuck frame.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DBIT        = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DBIT-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DBIT-1:0]          tx_din,
  output logic                     tx_start,
  input  logic                     tx_done_tick,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   gnt_id,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int unsigned IW  = clog2(NREQ);
  localparam int unsigned WDW = clog2(TIMEOUT_CYC);

  arb_state_t      state_q, state_d;
  logic [DBIT-1:0] din_q, din_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;

  logic [NREQ-1:0] arb_onehot;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .last       (last_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  // Sequencer: next state and next register values
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wd_d      = wd_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    err_d     = err_q & ~err_clr;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_onehot;
          gnt_d     = arb_idx;
          last_d    = arb_idx;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_onehot[i]) din_d = req_data[i*DBIT +: DBIT];
          end
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
          // Expiry beats a same-cycle err_clr since it is assigned last
          if (wd_d == WDW'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      din_q   <= '0;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      wd_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  assign tx_din      = din_q;
  assign tx_start    = start_q;
  assign busy        = busy_q;
  assign gnt_id      = gnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a stub transmitter answers tx_start
// after a programmable delay; grants, data and timing come from a queue-based model.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DBIT = 8;
  localparam int unsigned TOC  = 32;
  localparam int unsigned IW   = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_start;
  logic                 tx_done_tick;
  logic                 busy;
  logic [IW-1:0]        gnt_id;
  logic                 timeout_err;
  logic                 err_clr;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TIMEOUT_CYC(TOC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_din       (tx_din),
    .tx_start     (tx_start),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .gnt_id       (gnt_id),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [DBIT-1:0] bytes [NREQ];
  int   model_last;
  logic model_err;

  bit   stub_en;
  int   stub_delay;
  int   stub_cnt;
  logic stub_done;
  logic manual_done;

  assign tx_done_tick = stub_done | manual_done;

  // Stand-in transmitter: tx_done_tick stub_delay cycles after seeing tx_start
  always @(negedge clk) begin
    stub_done = 1'b0;
    if (!stub_en) stub_cnt = 0;
    else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) stub_done = 1'b1;
    end else if (tx_start) stub_cnt = stub_delay;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester order after 'last' wraps modulo NREQ; first valid one wins
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int order[$];
    for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
    foreach (order[j]) if (v[IW'(order[j])]) return order[j];
    return -1;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DBIT +: DBIT] = bytes[i];
  endtask

  // Called in the low phase of an IDLE cycle; returns in the low phase of the next IDLE cycle
  task automatic transfer(input logic [NREQ-1:0] v, input bit en, input int dly,
                          input int clr_at, input bit done_in_start,
                          input logic [NREQ-1:0] drop_mask);
    int i;
    int n;
    int exp_cnt;
    bit exp_timeout;
    stub_en    = en;
    stub_delay = dly;
    req_valid  = v;
    #1;
    i = pick(v, model_last);
    if (i < 0) begin
      check("idle_no_ready", 32'(req_ready), 0);
      @(negedge clk);
      check("idle_no_start", 32'(tx_start), 0);
      check("idle_no_busy", 32'(busy), 0);
      return;
    end
    check("ready_onehot", 32'(req_ready), 32'(1) << i);
    @(negedge clk);
    if (done_in_start) manual_done = 1'b1;
    check("start_pulse", 32'(tx_start), 1);
    check("din_at_start", 32'(tx_din), 32'(bytes[i]));
    check("gnt_id", 32'(gnt_id), i);
    check("busy_at_start", 32'(busy), 1);
    check("ready_low_start", 32'(req_ready), 0);
    model_last  = i;
    exp_timeout = !en || (dly >= int'(TOC));
    exp_cnt     = exp_timeout ? int'(TOC) : dly + 1;
    n = 0;
    do begin
      @(negedge clk);
      manual_done = 1'b0;
      n++;
      err_clr = (n == clr_at);
      if (drop_mask != 0 && n == 1) req_valid = drop_mask;
      if (drop_mask != 0 && n == 3) req_valid = '0;
      if (n == 1) check("start_one_cycle", 32'(tx_start), 0);
    end while (busy && n < int'(TOC) + 8);
    err_clr = 1'b0;
    check("wait_len", n, exp_cnt);
    if (clr_at > 0 && clr_at < exp_cnt) model_err = 1'b0;
    if (exp_timeout) model_err = 1'b1;
    check("timeout_err", 32'(timeout_err), 32'(model_err));
    check("din_hold", 32'(tx_din), 32'(bytes[i]));
    check("gnt_hold", 32'(gnt_id), i);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    err_clr     = 1'b0;
    manual_done = 1'b0;
    stub_en     = 1'b0;
    stub_delay  = 1;
    for (int i = 0; i < NREQ; i++) bytes[i] = '0;
    model_last = NREQ - 1;
    model_err  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_din", 32'(tx_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt_id", 32'(gnt_id), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester
    bytes[0] = 8'hA5;
    pack_data();
    transfer(4'b0001, 1'b1, 6, 0, 1'b0, '0);

    // All requesters continuously valid: grants rotate
    for (int i = 0; i < NREQ; i++) bytes[i] = DBIT'(8'h10 + i);
    pack_data();
    for (int r = 0; r < 8; r++) transfer(4'b1111, 1'b1, 3, 0, 1'b0, '0);

    // Wrap past 0/1 with only 2 and 3 requesting
    transfer(4'b0100, 1'b1, 2, 0, 1'b0, '0);
    transfer(4'b1100, 1'b1, 2, 0, 1'b0, '0);
    transfer(4'b1100, 1'b1, 2, 0, 1'b0, '0);

    // Done pulse during START is ignored; done pulse in IDLE is ignored
    transfer(4'b0010, 1'b1, 5, 0, 1'b1, '0);
    req_valid   = '0;
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    check("idle_done_busy", 32'(busy), 0);
    check("idle_done_start", 32'(tx_start), 0);

    // Request raised during WAIT then withdrawn before IDLE is never served
    transfer(4'b0001, 1'b1, 6, 0, 1'b0, 4'b1000);
    check("drop_no_ready", 32'(req_ready), 0);
    @(negedge clk);
    check("drop_no_start", 32'(tx_start), 0);
    check("drop_no_busy", 32'(busy), 0);
    check("drop_gnt_hold", 32'(gnt_id), 0);

    // Watchdog: expiry, clear, done on the last allowed cycle, expiry with clear
    transfer(4'b0010, 1'b0, 0, 0, 1'b0, '0);
    req_valid = '0;
    err_clr   = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    model_err = 1'b0;
    check("err_clr", 32'(timeout_err), 0);
    transfer(4'b0100, 1'b1, TOC - 1, 0, 1'b0, '0);
    transfer(4'b1000, 1'b1, TOC, 0, 1'b0, '0);
    transfer(4'b0001, 1'b0, 0, TOC - 1, 1'b0, '0);

    // Randomized traffic
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NREQ; i++) bytes[i] = DBIT'($urandom);
      pack_data();
      transfer(NREQ'($urandom_range(0, 15)), 1'b1, int'($urandom_range(1, 12)), 0, 1'b0, '0);
    end

    // Asynchronous reset in the middle of WAIT
    bytes[1] = 8'h5A;
    pack_data();
    transfer(4'b0001, 1'b0, 0, 0, 1'b0, '0);
    stub_en   = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_tx_din", 32'(tx_din), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_gnt_id", 32'(gnt_id), 0);
    check("mid_rst_timeout_err", 32'(timeout_err), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = NREQ - 1;
    model_err  = 1'b0;
    for (int i = 0; i < NREQ; i++) bytes[i] = DBIT'(8'hC0 + i);
    pack_data();
    transfer(4'b1111, 1'b1, 4, 0, 1'b0, '0);
    transfer(4'b1111, 1'b1, 4, 0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
